latch_wr_arbiter: RTL and testbench



---
 rtl/latch_wr_arbiter_if.sv | 26 ++
 rtl/latch_wr_arbiter.sv | 108 ++++++++++
 tb/tb_latch_wr_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/latch_wr_arbiter_if.sv
// Request/grant/latch-bank bus of latch_wr_arbiter.
// master = requester side (drives req/addr/data), slave = the arbiter.
interface latch_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic [(1<<AW)-1:0]   lat_en;
    logic [DW-1:0]        lat_d;
    logic                 busy;

    modport master (
        output req, req_addr, req_data,
        input  gnt, ack, lat_en, lat_d, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, ack, lat_en, lat_d, busy
    );
endinterface

// File: rtl/latch_wr_arbiter.sv
// Round-robin write arbiter/sequencer (SETUP/OPEN/HOLD) for a D-latch bank.
// Define LATCH_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module latch_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    latch_wr_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NW = 1 << AW;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
`ifndef LATCH_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   ptr_q, ptr_d;
`endif

    logic [NREQ-1:0] cand;
    logic            found;
    logic [IW-1:0]   win;

    // The current winner is excluded while it sits in HOLD.
    always_comb begin
        cand  = (state_q == HOLD) ? (bus.req & ~gnt_q) : bus.req;
        found = 1'b0;
        win   = '0;
`ifdef LATCH_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && cand[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
`else
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifndef LATCH_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE, HOLD: begin
                if (found) begin
                    state_d = SETUP;
                    gnt_d   = NREQ'(1) << win;
                    addr_d  = bus.req_addr[win*AW +: AW];
                    data_d  = bus.req_data[win*DW +: DW];
`ifndef LATCH_ARB_FIXED_PRIO_EN
                    ptr_d   = win;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            SETUP:   state_d = OPEN;
            OPEN:    state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            ptr_q   <= IW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // All outputs decode registered state, so reset clears them immediately.
    assign bus.gnt    = gnt_q;
    assign bus.ack    = (state_q == HOLD) ? gnt_q : '0;
    assign bus.lat_en = (state_q == OPEN) ? (NW'(1) << addr_q) : '0;
    assign bus.lat_d  = data_q;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Directed self-checking bench for latch_wr_arbiter with a behavioural latch bank.
module tb_latch_wr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mem [4];

    latch_wr_arbiter_if #(.NREQ(4), .DW(8), .AW(2)) bus ();

    latch_wr_arbiter #(.NREQ(4), .DW(8), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_latch begin
        for (int i = 0; i < 4; i++)
            if (bus.lat_en[i]) mem[i] <= bus.lat_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        #12;
        chk("rst_gnt",    32'(bus.gnt),    32'h0);
        chk("rst_ack",    32'(bus.ack),    32'h0);
        chk("rst_lat_en", 32'(bus.lat_en), 32'h0);
        chk("rst_lat_d",  32'(bus.lat_d),  32'h0);
        chk("rst_busy",   32'(bus.busy),   32'h0);
        rst_n = 1'b1;
        tick();

        // Single write: requester 0, addr 2, data A5
        bus.req_addr[0 +: 2] = 2'd2;
        bus.req_data[0 +: 8] = 8'hA5;
        bus.req = 4'b0001;
        tick();
        chk("w1_setup_gnt",    32'(bus.gnt),    32'h1);
        chk("w1_setup_lat_en", 32'(bus.lat_en), 32'h0);
        chk("w1_setup_lat_d",  32'(bus.lat_d),  32'hA5);
        chk("w1_setup_ack",    32'(bus.ack),    32'h0);
        chk("w1_setup_busy",   32'(bus.busy),   32'h1);
        tick();
        chk("w1_open_gnt",    32'(bus.gnt),    32'h1);
        chk("w1_open_lat_en", 32'(bus.lat_en), 32'h4);
        chk("w1_open_ack",    32'(bus.ack),    32'h0);
        tick();
        chk("w1_hold_gnt",    32'(bus.gnt),    32'h1);
        chk("w1_hold_lat_en", 32'(bus.lat_en), 32'h0);
        chk("w1_hold_ack",    32'(bus.ack),    32'h1);
        chk("w1_hold_lat_d",  32'(bus.lat_d),  32'hA5);
        bus.req = 4'b0000;
        tick();
        chk("w1_idle_busy",  32'(bus.busy),  32'h0);
        chk("w1_idle_gnt",   32'(bus.gnt),   32'h0);
        chk("w1_idle_ack",   32'(bus.ack),   32'h0);
        chk("w1_idle_lat_d", 32'(bus.lat_d), 32'hA5);
        chk("w1_mem2",       32'(mem[2]),    32'hA5);

        // Round-robin with all requesters asserted continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*2 +: 2] = 2'(i);
            bus.req_data[i*8 +: 8] = 8'(8'h10 + i);
        end
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr%0d_setup_gnt", k), 32'(bus.gnt), 32'(1) << order[k]);
            chk($sformatf("rr%0d_setup_ack", k), 32'(bus.ack), 32'h0);
            tick();
            chk($sformatf("rr%0d_open_lat_en", k), 32'(bus.lat_en), 32'(1) << order[k]);
            chk($sformatf("rr%0d_open_ack", k), 32'(bus.ack), 32'h0);
            tick();
            chk($sformatf("rr%0d_hold_ack", k), 32'(bus.ack), 32'(1) << order[k]);
            if (k == 4) bus.req = 4'b0000;
            tick();
        end
        chk("rr_idle_busy", 32'(bus.busy), 32'h0);
        chk("rr_mem1",      32'(mem[1]),   32'h11);
        chk("rr_mem3",      32'(mem[3]),   32'h13);

        // Data bus changes after grant are ignored
        bus.req_addr[2 +: 2] = 2'd3;
        bus.req_data[8 +: 8] = 8'h3C;
        bus.req = 4'b0010;
        tick();
        chk("cap_setup_gnt",  32'(bus.gnt),   32'h2);
        chk("cap_setup_lat_d", 32'(bus.lat_d), 32'h3C);
        bus.req_data[8 +: 8] = 8'hFF;
        tick();
        chk("cap_open_lat_d",  32'(bus.lat_d),  32'h3C);
        chk("cap_open_lat_en", 32'(bus.lat_en), 32'h8);
        tick();
        chk("cap_hold_ack",   32'(bus.ack),   32'h2);
        chk("cap_hold_lat_d", 32'(bus.lat_d), 32'h3C);
        bus.req = 4'b0000;
        tick();
        chk("cap_mem3", 32'(mem[3]), 32'h3C);

        // req[2] dropped during OPEN still completes
        bus.req_addr[4 +: 2] = 2'd0;
        bus.req_data[16 +: 8] = 8'h5A;
        bus.req = 4'b0100;
        tick();
        chk("drop_setup_gnt", 32'(bus.gnt), 32'h4);
        tick();
        chk("drop_open_lat_en", 32'(bus.lat_en), 32'h1);
        bus.req = 4'b0000;
        tick();
        chk("drop_hold_ack", 32'(bus.ack), 32'h4);
        tick();
        chk("drop_idle_busy", 32'(bus.busy), 32'h0);
        chk("drop_idle_gnt",  32'(bus.gnt),  32'h0);
        chk("drop_mem0",      32'(mem[0]),   32'h5A);

        // Asynchronous reset in the middle of OPEN
        bus.req = 4'b1000;
        tick();
        tick();
        chk("ar_open_lat_en", 32'(bus.lat_en), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("ar_lat_en", 32'(bus.lat_en), 32'h0);
        chk("ar_gnt",    32'(bus.gnt),    32'h0);
        chk("ar_ack",    32'(bus.ack),    32'h0);
        chk("ar_busy",   32'(bus.busy),   32'h0);
        #1;
        rst_n = 1'b1;
        bus.req = 4'b1001;
        tick();
        chk("ar_first_gnt", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        chk("ar_first_ack", 32'(bus.ack), 32'h1);
        bus.req = 4'b0000;
        tick();
        chk("ar_idle_busy", 32'(bus.busy), 32'h0);

        // Two writes to the same address: later grant wins
        do_reset();
        bus.req_addr[0 +: 2] = 2'd1;
        bus.req_addr[6 +: 2] = 2'd1;
        bus.req_data[0 +: 8]  = 8'h11;
        bus.req_data[24 +: 8] = 8'h33;
        bus.req = 4'b1001;
        tick();
        chk("same_a_gnt",   32'(bus.gnt),   32'h1);
        chk("same_a_lat_d", 32'(bus.lat_d), 32'h11);
        tick();
        chk("same_a_lat_en", 32'(bus.lat_en), 32'h2);
        tick();
        chk("same_a_ack", 32'(bus.ack), 32'h1);
        bus.req = 4'b1000;
        tick();
        chk("same_b_gnt",   32'(bus.gnt),   32'h8);
        chk("same_b_lat_d", 32'(bus.lat_d), 32'h33);
        tick();
        chk("same_b_lat_en", 32'(bus.lat_en), 32'h2);
        tick();
        chk("same_b_ack", 32'(bus.ack), 32'h8);
        bus.req = 4'b0000;
        tick();
        chk("same_idle_busy", 32'(bus.busy), 32'h0);
        chk("same_mem1",      32'(mem[1]),   32'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
